// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus an MMIO window with an
// output FIFO (TX), status, free-running cycle counter and dropped-push counter.
module dmem_mmio #(
    parameter int unsigned MEM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [32:0] RAM_BYTES     = 33'(MEM_WORDS) * 33'd4;
    localparam logic [PW:0] FIFO_FULL_CNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [13:0] REG_TX     = 14'd0;
    localparam logic [13:0] REG_STATUS = 14'd1;
    localparam logic [13:0] REG_CYCLE  = 14'd2;
    localparam logic [13:0] REG_DROPS  = 14'd3;

    // Accesses are word-only; the byte offset is deliberately discarded.
    logic unused_byte_offset;
    assign unused_byte_offset = &{1'b0, address_to_mem[1:0]};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic in_ram, in_mmio;
    logic sel_tx, sel_status, sel_cycle, sel_drops;

    assign in_ram     = {1'b0, address_to_mem} < RAM_BYTES;
    assign in_mmio    = address_to_mem[31:16] == MMIO_BASE[31:16];
    assign sel_tx     = in_mmio && (address_to_mem[15:2] == REG_TX);
    assign sel_status = in_mmio && (address_to_mem[15:2] == REG_STATUS);
    assign sel_cycle  = in_mmio && (address_to_mem[15:2] == REG_CYCLE);
    assign sel_drops  = in_mmio && (address_to_mem[15:2] == REG_DROPS);

    // ------------------------------------------------------------------
    // Data RAM (contents not reset)
    // ------------------------------------------------------------------
    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] ram_idx;

    assign ram_idx = address_to_mem[AW+1:2];

    always_ff @(posedge clk) begin
        if (!reset && WE && in_ram) begin
            ram[ram_idx] <= data_to_mem;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // Handshake: a word transfers on a rising edge where out_valid && out_ready
    // are both high; out_valid never depends on out_ready, and out_data stays
    // stable while out_valid is high and out_ready is low.
    // ------------------------------------------------------------------
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_empty, fifo_full;
    logic          push_req, pop, push_ok, drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL_CNT);
    assign push_req   = WE && sel_tx;
    assign pop        = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            fifo_mem[wr_ptr] <= data_to_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and dropped-push counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;
    logic [31:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'h0;
        end else if (WE && sel_cycle) begin
            cycle_cnt <= data_to_mem;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Saturates rather than wrapping so a long-running overflow stays visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 32'h0;
        end else if (WE && sel_drops) begin
            drop_cnt <= 32'h0;
        end else if (drop && (drop_cnt != 32'hFFFFFFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read path (pre-edge state, no side effects)
    // ------------------------------------------------------------------
    logic [31:0] status_word;

    assign status_word = {16'h0, 8'(count), 6'h0, fifo_full, fifo_empty};

    always_comb begin
        data_from_mem = 32'h0;
        if (in_ram) begin
            data_from_mem = ram[ram_idx];
        end else if (sel_status) begin
            data_from_mem = status_word;
        end else if (sel_cycle) begin
            data_from_mem = cycle_cnt;
        end else if (sel_drops) begin
            data_from_mem = drop_cnt;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed testbench for dmem_mmio: RAM decode, FIFO drain/full/drop,
// push+pop at full, cycle counter wrap and mid-operation reset.
module tb_dmem_mmio;

    localparam logic [31:0] TX_A     = 32'hFFFF0000;
    localparam logic [31:0] STATUS_A = 32'hFFFF0004;
    localparam logic [31:0] CYCLE_A  = 32'hFFFF0008;
    localparam logic [31:0] DROPS_A  = 32'hFFFF000C;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_cmp;
    int n_fail;
    logic [31:0] rv;
    logic [31:0] exp_w;
    logic [31:0] exp_q[$];

    dmem_mmio dut (
        .clk            (clk),
        .reset          (reset),
        .WE             (WE),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    // Clock / reset: wide period so several combinational reads fit in one phase.
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Driver tasks: called just after a falling edge, return just after the next one.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        WE = 1'b1;
        address_to_mem = a;
        data_to_mem = d;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        address_to_mem = a;
        #1;
        d = data_from_mem;
    endtask

    task automatic push(input logic [31:0] d);
        if (exp_q.size() < 8) exp_q.push_back(d);
        wr(TX_A, d);
    endtask

    task automatic drain(input int n, input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_w) begin
                n_fail++;
                $display("FAIL %s[%0d]: valid=%b data=%h, required valid=1 data=%h", tag, i, out_valid, out_data, exp_w);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rd(CYCLE_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL reset_cycle: got %h required 00000000", rv); end
        rd(DROPS_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL reset_drops: got %h required 00000000", rv); end
        rd(STATUS_A, rv);
        n_cmp++; if (rv !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h required 00000001", rv); end
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out: valid=%b data=%h required 0/0", out_valid, out_data); end
    endtask

    task automatic test_ram;
        wr(32'h14, 32'h11111111);
        wr(32'h10, 32'hDEADBEEF);
        rd(32'h10, rv);
        n_cmp++; if (rv !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_0x10: got %h required deadbeef", rv); end
        rd(32'h11, rv);
        n_cmp++; if (rv !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_0x11: got %h required deadbeef", rv); end
        rd(32'h14, rv);
        n_cmp++; if (rv !== 32'h11111111) begin n_fail++; $display("FAIL ram_0x14: got %h required 11111111", rv); end
        rd(32'h80000000, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h required 00000000", rv); end
        // Same-cycle write must read the pre-edge word.
        WE = 1'b1; address_to_mem = 32'h10; data_to_mem = 32'hA5A5A5A5;
        #1;
        n_cmp++; if (data_from_mem !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_preedge: got %h required deadbeef", data_from_mem); end
        @(negedge clk);
        WE = 1'b0;
        rd(32'h10, rv);
        n_cmp++; if (rv !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ram_overwrite: got %h required a5a5a5a5", rv); end
        // First byte past the RAM must not alias word 0.
        wr(32'h0, 32'h0BADC0DE);
        wr(32'h400, 32'h12345678);
        wr(32'h80000000, 32'h87654321);
        rd(32'h0, rv);
        n_cmp++; if (rv !== 32'h0BADC0DE) begin n_fail++; $display("FAIL ram_alias: got %h required 0badc0de", rv); end
        rd(32'h400, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL ram_limit: got %h required 00000000", rv); end
        rd(32'hFFFF0010, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL mmio_hole: got %h required 00000000", rv); end
    endtask

    task automatic test_fifo_drain;
        out_ready = 1'b0;
        // No fall-through: the pushed word is not visible before the edge.
        WE = 1'b1; address_to_mem = TX_A; data_to_mem = 32'd1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_fallthrough: valid=%b required 0", out_valid); end
        exp_q.push_back(32'd1);
        @(negedge clk);
        WE = 1'b0;
        push(32'd2);
        push(32'd3);
        rd(STATUS_A, rv);
        n_cmp++; if (rv !== 32'h0300) begin n_fail++; $display("FAIL drain_status: got %h required 00000300", rv); end
        rd(TX_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL tx_read: got %h required 00000000", rv); end
        drain(3, "drain");
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL drain_empty: valid=%b data=%h required 0/0", out_valid, out_data); end
        wr(STATUS_A, 32'hFFFFFFFF);
        rd(STATUS_A, rv);
        n_cmp++; if (rv !== 32'h0001) begin n_fail++; $display("FAIL drain_status_end: got %h required 00000001", rv); end
    endtask

    task automatic test_full_drop;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(32'h100 + 32'(i));
        rd(STATUS_A, rv);
        n_cmp++; if (rv !== 32'h0802) begin n_fail++; $display("FAIL full_status: got %h required 00000802", rv); end
        rd(DROPS_A, rv);
        n_cmp++; if (rv !== 32'h1) begin n_fail++; $display("FAIL full_drops: got %h required 00000001", rv); end
        n_cmp++; if (out_data !== 32'h100) begin n_fail++; $display("FAIL full_head: got %h required 00000100", out_data); end
        wr(DROPS_A, 32'h5A5A5A5A);
        rd(DROPS_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL drops_clear: got %h required 00000000", rv); end
        drain(8, "full_drain");
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        for (int i = 10; i < 18; i++) push(32'(i));
        // Push 99 and pop 10 on the same edge while full.
        WE = 1'b1; address_to_mem = TX_A; data_to_mem = 32'd99; out_ready = 1'b1;
        #1;
        n_cmp++; if (out_data !== 32'd10) begin n_fail++; $display("FAIL pp_head: got %h required 0000000a", out_data); end
        void'(exp_q.pop_front());
        exp_q.push_back(32'd99);
        @(negedge clk);
        WE = 1'b0; out_ready = 1'b0;
        rd(STATUS_A, rv);
        n_cmp++; if (rv !== 32'h0802) begin n_fail++; $display("FAIL pp_status: got %h required 00000802", rv); end
        rd(DROPS_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL pp_drops: got %h required 00000000", rv); end
        drain(8, "pp_drain");
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: valid=%b required 0", out_valid); end
    endtask

    task automatic test_cycle;
        wr(CYCLE_A, 32'hFFFFFFFE);
        rd(CYCLE_A, rv);
        n_cmp++; if (rv !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL cycle_load: got %h required fffffffe", rv); end
        @(negedge clk);
        rd(CYCLE_A, rv);
        n_cmp++; if (rv !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL cycle_inc: got %h required ffffffff", rv); end
        @(negedge clk);
        rd(CYCLE_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap: got %h required 00000000", rv); end
    endtask

    task automatic test_reset_mid;
        wr(32'h20, 32'hCAFEF00D);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(i));
        reset = 1'b1; WE = 1'b1; address_to_mem = TX_A; data_to_mem = 32'h55; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; WE = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out: valid=%b data=%h required 0/0", out_valid, out_data); end
        rd(STATUS_A, rv);
        n_cmp++; if (rv !== 32'h0001) begin n_fail++; $display("FAIL rst_status: got %h required 00000001", rv); end
        rd(CYCLE_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL rst_cycle: got %h required 00000000", rv); end
        rd(DROPS_A, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL rst_drops: got %h required 00000000", rv); end
        rd(32'h20, rv);
        n_cmp++; if (rv !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_ram: got %h required cafef00d", rv); end
        push(32'h77);
        rd(STATUS_A, rv);
        n_cmp++; if (rv !== 32'h0100) begin n_fail++; $display("FAIL rst_push_status: got %h required 00000100", rv); end
        drain(1, "rst_head");
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        WE = 1'b0;
        address_to_mem = 32'h0;
        data_to_mem = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        test_reset;
        test_ram;
        test_fifo_drain;
        test_full_drop;
        test_back_to_back;
        test_cycle;
        test_reset_mid;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
